// File: rtl/div_unit_pkg.sv
//------------------------------------------------------------------------------
// div_unit_pkg : shared CPU constants for the execute-stage ALU and divider.
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package div_unit_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  // Combinational ALU operation encodings, kept alongside the divider ops
  typedef logic [3:0] alu_op_t;
  localparam alu_op_t ALU_ADD  = 4'd0;
  localparam alu_op_t ALU_SUB  = 4'd1;
  localparam alu_op_t ALU_SLL  = 4'd2;
  localparam alu_op_t ALU_SLT  = 4'd3;
  localparam alu_op_t ALU_SLTU = 4'd4;
  localparam alu_op_t ALU_XOR  = 4'd5;
  localparam alu_op_t ALU_SRL  = 4'd6;
  localparam alu_op_t ALU_SRA  = 4'd7;
  localparam alu_op_t ALU_OR   = 4'd8;
  localparam alu_op_t ALU_AND  = 4'd9;

  typedef logic [1:0] div_op_t;
  localparam div_op_t DIV  = 2'd0;
  localparam div_op_t DIVU = 2'd1;
  localparam div_op_t REM  = 2'd2;
  localparam div_op_t REMU = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic logic op_is_signed(input div_op_t op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_t op);
    return op[1];
  endfunction

  function automatic logic [WIDTH-1:0] abs_if(input logic [WIDTH-1:0] v, input logic en);
    return (en && v[WIDTH-1]) ? -v : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_unit_if.sv
//------------------------------------------------------------------------------
// div_unit_if : request/response handshake bundle between execute and divider.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface div_unit_if;
  import div_unit_pkg::*;

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  div_op_t            operation;
  logic [WIDTH-1:0]   X;
  logic [WIDTH-1:0]   Y;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   O;
  logic               busy;

  modport master (
    output flush, in_valid, operation, X, Y, out_ready,
    input  in_ready, out_valid, O, busy
  );

  modport slave (
    input  flush, in_valid, operation, X, Y, out_ready,
    output in_ready, out_valid, O, busy
  );

endinterface

`default_nettype wire

// File: rtl/div_unit.sv
//------------------------------------------------------------------------------
// div_unit : iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  div_unit_if.slave   bus
);

  div_state_t         r_state;
  div_op_t            r_op;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_div;
  logic [WIDTH-1:0]   r_o;
  logic [CNT_W-1:0]   r_count;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  logic               w_signed;
  logic               w_x_neg;
  logic               w_y_neg;
  logic               w_y_zero;
  logic               w_ovf;
  logic               w_special;
  logic               w_accept;
  logic [WIDTH-1:0]   w_special_o;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_rem_nx;
  logic [WIDTH-1:0]   w_quo_nx;
  logic [WIDTH-1:0]   w_result;

  assign w_signed  = op_is_signed(bus.operation);
  assign w_x_neg   = w_signed & bus.X[WIDTH-1];
  assign w_y_neg   = w_signed & bus.Y[WIDTH-1];
  assign w_y_zero  = (bus.Y == '0);
  assign w_ovf     = w_signed && (bus.X == 32'h8000_0000) && (bus.Y == 32'hFFFF_FFFF);
  assign w_special = w_y_zero | w_ovf;
  assign w_accept  = bus.in_valid & r_in_ready;

  always_comb begin
    w_special_o = '0;
    if (w_y_zero) begin
      w_special_o = op_is_rem(bus.operation) ? bus.X : '1;
    end else if (w_ovf) begin
      w_special_o = op_is_rem(bus.operation) ? '0 : 32'h8000_0000;
    end
  end

  // Remainder stays below the divisor, so a 33-bit trial sign is exact
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_div};
  assign w_rem_nx = w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_nx = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};

  always_comb begin
    w_result = w_quo_nx;
    case (r_op)
      DIV:     w_result = r_neg_q ? -w_quo_nx : w_quo_nx;
      DIVU:    w_result = w_quo_nx;
      REM:     w_result = r_neg_r ? -w_rem_nx : w_rem_nx;
      REMU:    w_result = w_rem_nx;
      default: w_result = w_quo_nx;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= DIV;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_o         <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (bus.flush) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op       <= bus.operation;
            r_neg_q    <= w_x_neg ^ w_y_neg;
            r_neg_r    <= w_x_neg;
            r_rem      <= '0;
            r_quo      <= abs_if(bus.X, w_signed);
            r_div      <= abs_if(bus.Y, w_signed);
            r_count    <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_special) begin
              r_o         <= w_special_o;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_state     <= RUN;
            end
          end
        end
        RUN: begin
          r_rem   <= w_rem_nx;
          r_quo   <= w_quo_nx;
          r_count <= r_count + 5'd1;
          if (r_count == 5'd31) begin
            r_o         <= w_result;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.O         = r_o;
  assign bus.busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
//------------------------------------------------------------------------------
// tb_div_unit : randomized and directed self-checking bench for div_unit.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_div_unit;
  import div_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  div_unit_if bus();

  div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: RV32M semantics from plain SV arithmetic
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] x,
                                        input logic [31:0] y);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (y == 32'd0) return (op == REM || op == REMU) ? x : 32'hFFFF_FFFF;
    if ((op == DIV || op == REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
      return (op == DIV) ? 32'h8000_0000 : 32'd0;
    q = $signed(x) / $signed(y);
    r = $signed(x) % $signed(y);
    case (op)
      DIV:     return q;
      REM:     return r;
      DIVU:    return x / y;
      default: return x % y;
    endcase
  endfunction

  // Presents one request and waits for out_valid; lat counts edges from drive
  task automatic run_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    bus.operation = op;
    bus.X         = x;
    bus.Y         = y;
    bus.in_valid  = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
      if (lat == 1) begin
        bus.in_valid  = 1'b0;
        bus.X         = $urandom;
        bus.Y         = $urandom;
        bus.operation = 2'($urandom);
      end
    end while (!bus.out_valid && lat < 200);
    res = bus.O;
  endtask

  task automatic handoff();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    total++; if (bus.O !== 32'd0) $display("FAIL reset_O: got %h want 0", bus.O); else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [1:0]  ops  [9] = '{DIVU, REMU, DIV, REM, REM, DIV, REMU, DIV, REM};
    logic [31:0] xs   [9] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] ys   [9] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exps [9] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1,
                              32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int          lats [9] = '{33, 33, 33, 33, 33, 1, 1, 1, 1};
    logic [31:0] res;
    int          lat;
    for (int i = 0; i < 9; i++) begin
      run_op(ops[i], xs[i], ys[i], res, lat);
      total++;
      if (res !== exps[i]) $display("FAIL directed_O[%0d]: got %h want %h", i, res, exps[i]);
      else passed++;
      total++;
      if (lat !== lats[i]) $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, lats[i]);
      else passed++;
      handoff();
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
        $display("FAIL directed_handoff[%0d]: in_ready=%b out_valid=%b want 1/0", i, bus.in_ready, bus.out_valid);
      else passed++;
    end
  endtask

  task automatic test_hold();
    logic [31:0] x, y, exp, res;
    int          lat;
    x = $urandom; y = $urandom_range(1, 1000);
    exp = model(DIVU, x, y);
    run_op(DIVU, x, y, res, lat);
    total++; if (res !== exp) $display("FAIL hold_O: got %h want %h", res, exp); else passed++;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.O !== exp || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
        $display("FAIL hold_stable[%0d]: O=%h in_ready=%b out_valid=%b want %h/0/1",
                 i, bus.O, bus.in_ready, bus.out_valid, exp);
      else passed++;
    end
    handoff();
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL hold_release: out_valid=%b in_ready=%b busy=%b want 0/1/0",
               bus.out_valid, bus.in_ready, bus.busy);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int  n;
    int  valid_at;
    logic [31:0] res;
    int  lat;
    bus.out_ready = 1'b1;
    bus.operation = DIVU; bus.X = 32'd50; bus.Y = 32'd5; bus.in_valid = 1'b1;
    n = 0; valid_at = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) begin bus.X = 32'd81; bus.Y = 32'd9; end
      if (bus.out_valid && valid_at == 0) begin
        valid_at = n;
        total++; if (bus.O !== 32'd10) $display("FAIL b2b_first_O: got %h want %h", bus.O, 32'd10); else passed++;
      end
    end while (!(n > 1 && bus.in_ready) && n < 200);
    total++; if (valid_at !== 33) $display("FAIL b2b_valid_edge: got %0d want 33", valid_at); else passed++;
    total++; if (n !== 34) $display("FAIL b2b_ready_edge: got %0d want 34", n); else passed++;
    run_op(DIVU, 32'd81, 32'd9, res, lat);
    total++; if (res !== 32'd9) $display("FAIL b2b_second_O: got %h want %h", res, 32'd9); else passed++;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int          lat;
    int          seen;
    bus.operation = DIVU; bus.X = 32'hFFFF_FFF0; bus.Y = 32'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL flush_abort: out_valid=%b in_ready=%b busy=%b want 0/1/0",
               bus.out_valid, bus.in_ready, bus.busy);
    else passed++;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.out_valid) seen++; end
    total++; if (seen !== 0) $display("FAIL flush_no_valid: got %0d valid cycles want 0", seen); else passed++;
    run_op(DIVU, 32'd9, 32'd3, res, lat);
    total++; if (res !== 32'd3) $display("FAIL flush_recover_O: got %h want %h", res, 32'd3); else passed++;
    handoff();

    bus.operation = DIV; bus.X = 32'd1000; bus.Y = 32'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.O !== 32'd0)
      $display("FAIL reset_mid_run: in_ready=%b out_valid=%b busy=%b O=%h want 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.busy, bus.O);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(REM, 32'hFFFF_FFF9, 32'd2, res, lat);
    total++; if (res !== 32'hFFFF_FFFF) $display("FAIL reset_recover_O: got %h want %h", res, 32'hFFFF_FFFF); else passed++;
    handoff();
  endtask

  task automatic test_random();
    logic [31:0] x, y, exp, res;
    int          lat;
    int          sel;
    bus.out_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      for (int i = 0; i < 32; i++) begin
        sel = $urandom_range(0, 7);
        x = (sel == 7) ? 32'h8000_0000 : $urandom;
        if (sel == 0)      y = 32'd0;
        else if (sel < 3)  y = $urandom_range(1, 255);
        else if (sel == 3 || sel == 7) y = 32'hFFFF_FFFF;
        else               y = $urandom;
        exp = model(2'(op), x, y);
        run_op(2'(op), x, y, res, lat);
        total++;
        if (res !== exp || lat >= 200)
          $display("FAIL random_op%0d[%0d]: x=%h y=%h got %h want %h lat=%0d", op, i, x, y, res, exp, lat);
        else passed++;
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.operation = DIV;
    bus.X         = '0;
    bus.Y         = '0;
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
